// File: rtl/gt_reset_pkg.sv
// Shared types and constants for the GT reset sequencer and the per-stage GT reset logic.
package gt_reset_pkg;
  localparam int CNT_W   = 16;
  localparam int RETRY_W = 4;
  localparam int IDX_W   = 8;

  localparam int DEF_NSTAGE      = 3;
  localparam int DEF_RESETLENGTH = 4;
  localparam int DEF_READYLENGTH = 10;
  localparam int DEF_TIMEOUT     = 50000;
  localparam int DEF_MAXRETRY    = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_PULSE,
    ST_WAIT_DONE,
    ST_DONE,
    ST_FAIL
  } state_e;
endpackage

// File: rtl/gt_reset_sequencer_filter.sv
// gt_ready_filter: qualifies din once it has been sampled high LENGTH consecutive cycles.
module gt_ready_filter #(
  parameter int LENGTH = 10
) (
  input  logic stableclk,
  input  logic rstn,
  input  logic clear,
  input  logic din,
  output logic qualified
);
  logic [LENGTH-1:0] shift_q;
  logic [LENGTH-1:0] shift_d;

  always_comb begin
    shift_d = clear ? '0 : {shift_q[LENGTH-2:0], din};
  end

  always_ff @(posedge stableclk or negedge rstn) begin
    if (!rstn) shift_q <= '0;
    else       shift_q <= shift_d;
  end

  assign qualified = &shift_q;
endmodule

// File: rtl/gt_reset_sequencer.sv
// Sequences the GT reset chain stage by stage: ready-qualify, reset pulse, wait-for-done with retries.
// Optional GT_RESET_SEQ_AUTORESTART_EN re-runs a stage from DONE when its donein falls off persistently.
module gt_reset_sequencer
  import gt_reset_pkg::*;
#(
  parameter int NSTAGE      = DEF_NSTAGE,
  parameter int RESETLENGTH = DEF_RESETLENGTH,
  parameter int READYLENGTH = DEF_READYLENGTH,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int MAXRETRY    = DEF_MAXRETRY
) (
  input  logic              stableclk,
  input  logic              rstn,
  input  logic              start,
  input  logic [NSTAGE-1:0] ready,
  input  logic [NSTAGE-1:0] donein,
  output logic [NSTAGE-1:0] stage_reset,
  output logic              busy,
  output logic              done,
  output logic              donestrobe,
  output logic              error,
  output logic [7:0]        error_stage,
  output logic [3:0]        retry_cnt
);
  if (NSTAGE < 1 || NSTAGE > 256 || RESETLENGTH < 1 || RESETLENGTH > 65535 ||
      READYLENGTH < 2 || TIMEOUT < 1 || TIMEOUT > 65536 ||
      MAXRETRY < 0 || MAXRETRY > 15) begin : g_param_check
    $error("gt_reset_sequencer: parameter out of range");
  end

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [CNT_W-1:0]     pulse_q, pulse_d;
  logic [CNT_W-1:0]     to_q, to_d;
  logic [NSTAGE-1:0]    stage_reset_q, stage_reset_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic                 donestrobe_q, donestrobe_d, error_q, error_d;
  logic [IDX_W-1:0]     error_stage_q, error_stage_d;

  logic                 ready_sel, donein_sel, ready_qual, ready_clear;
  logic [NSTAGE-1:0]    idx_onehot;

  always_comb begin
    ready_sel  = 1'b0;
    donein_sel = 1'b0;
    idx_onehot = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      if (idx_q == IDX_W'(k)) begin
        ready_sel     = ready[k];
        donein_sel    = donein[k];
        idx_onehot[k] = 1'b1;
      end
    end
  end

  gt_ready_filter #(.LENGTH(READYLENGTH)) u_ready_filter (
    .stableclk (stableclk),
    .rstn      (rstn),
    .clear     (ready_clear),
    .din       (ready_sel),
    .qualified (ready_qual)
  );

`ifdef GT_RESET_SEQ_AUTORESTART_EN
  logic [NSTAGE-1:0] fall_qual;
  logic              fall_clear, fall_any;
  logic [IDX_W-1:0]  fall_idx;

  // Falloff detectors only accumulate while sitting in DONE.
  assign fall_clear = (state_q != ST_DONE);

  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_fall
    gt_ready_filter #(.LENGTH(READYLENGTH)) u_fall_filter (
      .stableclk (stableclk),
      .rstn      (rstn),
      .clear     (fall_clear),
      .din       (~donein[gi]),
      .qualified (fall_qual[gi])
    );
  end

  always_comb begin
    fall_any = 1'b0;
    fall_idx = '0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (fall_qual[k]) begin
        fall_any = 1'b1;
        fall_idx = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    retry_d       = retry_q;
    pulse_d       = pulse_q;
    to_d          = to_q;
    stage_reset_d = stage_reset_q;
    if (start) begin
      state_d       = ST_WAIT_READY;
      idx_d         = '0;
      retry_d       = '0;
      stage_reset_d = '0;
    end else begin
      case (state_q)
        ST_WAIT_READY: begin
          if (ready_qual) begin
            state_d       = ST_PULSE;
            pulse_d       = CNT_W'(RESETLENGTH);
            stage_reset_d = idx_onehot;
          end
        end
        ST_PULSE: begin
          if (pulse_q <= CNT_W'(1)) begin
            state_d       = ST_WAIT_DONE;
            stage_reset_d = '0;
            to_d          = '0;
          end else begin
            pulse_d = pulse_q - CNT_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          // A done sample beats a coincident timeout.
          if (donein_sel) begin
            if (idx_q == IDX_W'(NSTAGE - 1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_WAIT_READY;
              idx_d   = idx_q + IDX_W'(1);
              retry_d = '0;
            end
          end else if (to_q == CNT_W'(TIMEOUT - 1)) begin
            if (retry_q == RETRY_W'(MAXRETRY)) begin
              state_d = ST_FAIL;
            end else begin
              state_d = ST_WAIT_READY;
              retry_d = retry_q + RETRY_W'(1);
            end
          end else begin
            to_d = to_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
`ifdef GT_RESET_SEQ_AUTORESTART_EN
          if (fall_any) begin
            state_d = ST_WAIT_READY;
            idx_d   = fall_idx;
            retry_d = '0;
          end
`endif
        end
        ST_FAIL:  stage_reset_d = '0;
        default:  state_d = ST_IDLE;
      endcase
    end

    ready_clear   = (state_d == ST_WAIT_READY) && ((state_q != ST_WAIT_READY) || start);
    busy_d        = (state_d == ST_WAIT_READY) || (state_d == ST_PULSE) || (state_d == ST_WAIT_DONE);
    done_d        = (state_d == ST_DONE);
    donestrobe_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
    error_d       = (state_d == ST_FAIL);
    error_stage_d = idx_d;
  end

  always_ff @(posedge stableclk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      retry_q       <= '0;
      pulse_q       <= '0;
      to_q          <= '0;
      stage_reset_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      donestrobe_q  <= 1'b0;
      error_q       <= 1'b0;
      error_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      retry_q       <= retry_d;
      pulse_q       <= pulse_d;
      to_q          <= to_d;
      stage_reset_q <= stage_reset_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      donestrobe_q  <= donestrobe_d;
      error_q       <= error_d;
      error_stage_q <= error_stage_d;
    end
  end

  assign stage_reset = stage_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign donestrobe  = donestrobe_q;
  assign error       = error_q;
  assign error_stage = error_stage_q;
  assign retry_cnt   = retry_q;
endmodule

// File: tb/tb_gt_reset_sequencer.sv
// Scoreboard bench for gt_reset_sequencer: expected output events are queued, a monitor pops and compares.
module tb_gt_reset_sequencer;
  localparam int NS = 3;

  logic          stableclk = 1'b0;
  logic          rstn, start;
  logic [NS-1:0] ready, donein;
  logic [NS-1:0] stage_reset;
  logic          busy, done, donestrobe, error;
  logic [7:0]    error_stage;
  logic [3:0]    retry_cnt;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         kind;   // 0 stage_reset change, 1 donestrobe, 2 error rise
    int         cyc;
    logic [2:0] sr;
    logic [3:0] rc;
    logic [7:0] es;
    logic       dn, bz, er;
  } ev_t;
  ev_t expq[$];

  gt_reset_sequencer #(
    .NSTAGE(NS), .RESETLENGTH(4), .READYLENGTH(10), .TIMEOUT(100), .MAXRETRY(2)
  ) dut (
    .stableclk   (stableclk),
    .rstn        (rstn),
    .start       (start),
    .ready       (ready),
    .donein      (donein),
    .stage_reset (stage_reset),
    .busy        (busy),
    .done        (done),
    .donestrobe  (donestrobe),
    .error       (error),
    .error_stage (error_stage),
    .retry_cnt   (retry_cnt)
  );

  always #5 stableclk = ~stableclk;
  always @(posedge stableclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [2:0] sr, input logic [3:0] rc,
                      input logic [7:0] es, input logic dn, input logic bz, input logic er);
    ev_t e;
    e.kind = kind; e.cyc = c; e.sr = sr; e.rc = rc; e.es = es; e.dn = dn; e.bz = bz; e.er = er;
    expq.push_back(e);
  endtask

  task automatic at_neg(input int n);
    while (cyc < n) @(negedge stableclk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge stableclk);
    start = 1'b0;
  endtask

  task automatic end_test();
    chk("queue drained", expq.size(), 0);
    rstn = 1'b0; start = 1'b0; donein = '0; ready = '0;
    @(negedge stableclk);
    @(negedge stableclk);
    rstn = 1'b1;
    @(negedge stableclk);
  endtask

  task automatic check_ev(input int kind);
    ev_t o, e;
    o.kind = kind; o.cyc = cyc; o.sr = stage_reset; o.rc = retry_cnt; o.es = error_stage;
    o.dn = done; o.bz = busy; o.er = error;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL event: unexpected kind=%0d cyc=%0d sr=%b rc=%0d es=%0d dn=%b bz=%b er=%b",
               o.kind, o.cyc, o.sr, o.rc, o.es, o.dn, o.bz, o.er);
    end else begin
      e = expq.pop_front();
      if (o.kind != e.kind || o.cyc != e.cyc || o.sr !== e.sr || o.rc !== e.rc || o.es !== e.es ||
          o.dn !== e.dn || o.bz !== e.bz || o.er !== e.er) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d sr=%b rc=%0d es=%0d dn=%b bz=%b er=%b, expected kind=%0d cyc=%0d sr=%b rc=%0d es=%0d dn=%b bz=%b er=%b",
                 o.kind, o.cyc, o.sr, o.rc, o.es, o.dn, o.bz, o.er,
                 e.kind, e.cyc, e.sr, e.rc, e.es, e.dn, e.bz, e.er);
      end else begin
        $display("event ok: kind=%0d cyc=%0d sr=%b rc=%0d es=%0d", o.kind, o.cyc, o.sr, o.rc, o.es);
      end
    end
  endtask

  // Monitor: every output event is compared against the head of the queue.
  initial begin
    logic [NS-1:0] prev_sr;
    logic          prev_er;
    prev_sr = '0;
    prev_er = 1'b0;
    forever begin
      @(negedge stableclk);
      if (stage_reset !== prev_sr) check_ev(0);
      if (donestrobe === 1'b1)     check_ev(1);
      if (error === 1'b1 && !prev_er) check_ev(2);
      prev_sr = stage_reset;
      prev_er = error;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, x;
    rstn = 1'b0; start = 1'b0; ready = '0; donein = '0;
    @(negedge stableclk);
    @(negedge stableclk);
    chk("rst stage_reset", stage_reset, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst donestrobe", donestrobe, 0);
    chk("rst error", error, 0);
    chk("rst error_stage", error_stage, 0);
    chk("rst retry_cnt", retry_cnt, 0);
    rstn = 1'b1;
    repeat (3) @(negedge stableclk);
    chk("idle busy", busy, 0);
    chk("idle done", done, 0);

    // Nominal: donein[k] rises 20 cycles after each pulse falls.
    ready = '1;
    e0 = cyc + 1;
    push(0, e0 + 11,  3'b001, 0, 0, 0, 1, 0);
    push(0, e0 + 15,  3'b000, 0, 0, 0, 1, 0);
    push(0, e0 + 47,  3'b010, 0, 1, 0, 1, 0);
    push(0, e0 + 51,  3'b000, 0, 1, 0, 1, 0);
    push(0, e0 + 83,  3'b100, 0, 2, 0, 1, 0);
    push(0, e0 + 87,  3'b000, 0, 2, 0, 1, 0);
    push(1, e0 + 108, 3'b000, 0, 2, 1, 0, 0);
    pulse_start();
    at_neg(e0 + 35);  donein[0] = 1'b1;
    at_neg(e0 + 71);  donein[1] = 1'b1;
    at_neg(e0 + 107); donein[2] = 1'b1;
    at_neg(e0 + 115);
    chk("nominal done", done, 1);
    chk("nominal donestrobe low", donestrobe, 0);
    chk("nominal busy", busy, 0);
    chk("nominal error", error, 0);
`ifdef GT_RESET_SEQ_AUTORESTART_EN
    x = e0 + 120;
    push(0, x + 22, 3'b010, 0, 1, 0, 1, 0);
    push(0, x + 26, 3'b000, 0, 1, 0, 1, 0);
    push(0, x + 42, 3'b100, 0, 2, 0, 1, 0);
    push(0, x + 46, 3'b000, 0, 2, 0, 1, 0);
    push(1, x + 47, 3'b000, 0, 2, 1, 0, 0);
    at_neg(x); donein[1] = 1'b0;
    at_neg(x + 10);
    chk("autorestart still done", done, 1);
    at_neg(x + 11);
    chk("autorestart busy", busy, 1);
    chk("autorestart done cleared", done, 0);
    chk("autorestart stage", error_stage, 1);
    at_neg(x + 30); donein[1] = 1'b1;
    at_neg(x + 55);
    chk("autorestart done again", done, 1);
`endif
    end_test();

    // Ready glitch on stage 0 restarts the qualify count.
    ready = '1;
    e0 = cyc + 1;
    push(0, e0 + 17, 3'b001, 0, 0, 0, 1, 0);
    push(0, e0 + 21, 3'b000, 0, 0, 0, 1, 0);
    pulse_start();
    at_neg(e0 + 5); ready[0] = 1'b0;
    at_neg(e0 + 6); ready[0] = 1'b1;
    at_neg(e0 + 25);
    end_test();

    // Stage 1 never completes: three attempts then FAIL.
    ready = '1; donein = 3'b001;
    e0 = cyc + 1;
    push(0, e0 + 11,  3'b001, 0, 0, 0, 1, 0);
    push(0, e0 + 15,  3'b000, 0, 0, 0, 1, 0);
    push(0, e0 + 27,  3'b010, 0, 1, 0, 1, 0);
    push(0, e0 + 31,  3'b000, 0, 1, 0, 1, 0);
    push(0, e0 + 142, 3'b010, 1, 1, 0, 1, 0);
    push(0, e0 + 146, 3'b000, 1, 1, 0, 1, 0);
    push(0, e0 + 257, 3'b010, 2, 1, 0, 1, 0);
    push(0, e0 + 261, 3'b000, 2, 1, 0, 1, 0);
    push(2, e0 + 361, 3'b000, 2, 1, 0, 0, 1);
    pulse_start();
    at_neg(e0 + 370);
    chk("fail error", error, 1);
    chk("fail error_stage", error_stage, 1);
    chk("fail busy", busy, 0);
    chk("fail stage_reset", stage_reset, 0);
    chk("fail done", done, 0);
    end_test();

    // donein[2] arrives on the exact timeout cycle: done wins.
    ready = '1; donein = 3'b011;
    e0 = cyc + 1;
    push(0, e0 + 11,  3'b001, 0, 0, 0, 1, 0);
    push(0, e0 + 15,  3'b000, 0, 0, 0, 1, 0);
    push(0, e0 + 27,  3'b010, 0, 1, 0, 1, 0);
    push(0, e0 + 31,  3'b000, 0, 1, 0, 1, 0);
    push(0, e0 + 43,  3'b100, 0, 2, 0, 1, 0);
    push(0, e0 + 47,  3'b000, 0, 2, 0, 1, 0);
    push(1, e0 + 147, 3'b000, 0, 2, 1, 0, 0);
    pulse_start();
    at_neg(e0 + 146); donein[2] = 1'b1;
    at_neg(e0 + 170);
    chk("simul retry_cnt", retry_cnt, 0);
    chk("simul done", done, 1);
    end_test();

    // Restart during stage 1 pulse, then async reset mid WAIT_DONE.
    ready = '1; donein = 3'b001;
    e0 = cyc + 1;
    e1 = e0 + 29;
    push(0, e0 + 11, 3'b001, 0, 0, 0, 1, 0);
    push(0, e0 + 15, 3'b000, 0, 0, 0, 1, 0);
    push(0, e0 + 27, 3'b010, 0, 1, 0, 1, 0);
    push(0, e1,      3'b000, 0, 0, 0, 1, 0);
    push(0, e1 + 11, 3'b001, 0, 0, 0, 1, 0);
    push(0, e1 + 15, 3'b000, 0, 0, 0, 1, 0);
    push(0, e1 + 27, 3'b010, 0, 1, 0, 1, 0);
    push(0, e1 + 31, 3'b000, 0, 1, 0, 1, 0);
    pulse_start();
    at_neg(e1 - 1);
    pulse_start();
    at_neg(e1 + 40);
    chk("pre-rstn busy", busy, 1);
    chk("pre-rstn error_stage", error_stage, 1);
    #2 rstn = 1'b0;
    #1;
    chk("async stage_reset", stage_reset, 0);
    chk("async busy", busy, 0);
    chk("async done", done, 0);
    chk("async donestrobe", donestrobe, 0);
    chk("async error", error, 0);
    chk("async error_stage", error_stage, 0);
    chk("async retry_cnt", retry_cnt, 0);
    @(negedge stableclk);
    rstn = 1'b1;
    repeat (5) @(negedge stableclk);
    chk("post-rstn idle busy", busy, 0);
    chk("post-rstn idle stage_reset", stage_reset, 0);
    end_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
